// File: rtl/spi_slave_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regfile_pkg
// Description : Register map addresses, CTRL bit indices and reset values
//               shared by the SPI slave register file and its sub-blocks.
// Revision    : 1.0 - initial parametrised register file
// ============================================================================
package spi_slave_regfile_pkg;

    // Register map
    localparam int unsigned ADDR_CTRL    = 0;
    localparam int unsigned ADDR_DUMMY   = 1;
    localparam int unsigned ADDR_WRAP_LO = 2;
    localparam int unsigned ADDR_WRAP_HI = 3;
    localparam int unsigned ADDR_STATUS  = 4;
    localparam int unsigned ADDR_SCRATCH = 5;

    // CTRL bit positions; the lock bit is always the register MSB
    localparam int unsigned CTRL_QPI_BIT = 0;

    // Reset values (DUMMY reset comes from the top-level parameter)
    localparam int unsigned CTRL_RST    = 0;
    localparam int unsigned WRAP_RST    = 0;
    localparam int unsigned STATUS_RST  = 0;
    localparam int unsigned SCRATCH_RST = 0;

    // Lock bit index for a given register width
    function automatic int unsigned lock_bit(input int unsigned reg_size);
        return reg_size - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_status_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_status_reg
// Description : Sticky status register. Hardware set bits accumulate; a
//               qualified read clears everything, but a set in the same
//               cycle wins over the clear.
// Revision    : 1.0 - initial version
// ============================================================================
module spi_slave_status_reg #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] set_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;

    // Next state: clear first, then OR in new set bits so set wins
    always_comb begin
        status_d = (status_q & ~{WIDTH{clr_i}}) | set_i;
    end

    // Status state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= RST_VAL;
        end else begin
            status_q <= status_d;
        end
    end

    assign q_o = status_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regfile
// Description : SPI slave configuration register file in the sclk domain.
//               CTRL with set-only lock, DUMMY (zero writes ignored), wrap
//               length committed atomically through a LO shadow, sticky
//               clear-on-read STATUS, SCRATCH, and a config-update pulse.
// Revision    : 1.0 - initial parametrised register file
// ============================================================================
module spi_slave_regfile
    import spi_slave_regfile_pkg::*;
#(
    parameter  int REG_SIZE  = 8,
    parameter  int NUM_REGS  = 8,
    parameter  int DUMMY_RST = 32,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int WRAP_W    = 2 * REG_SIZE
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic [REG_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                wr_data_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_req,
    output logic [REG_SIZE-1:0] rd_data,
    input  logic [REG_SIZE-1:0] status_set,
    output logic [7:0]          dummy_cycles,
    output logic                en_qpi,
    output logic [WRAP_W-1:0]   wrap_length,
    output logic                locked,
    output logic                cfg_update
);

    localparam int unsigned LOCK_BIT = lock_bit(REG_SIZE);

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_DUMMY   = ADDR_W'(ADDR_DUMMY);
    localparam logic [ADDR_W-1:0] A_WRAP_LO = ADDR_W'(ADDR_WRAP_LO);
    localparam logic [ADDR_W-1:0] A_WRAP_HI = ADDR_W'(ADDR_WRAP_HI);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(ADDR_SCRATCH);

    logic [REG_SIZE-1:0] ctrl_q,    ctrl_d;
    logic [REG_SIZE-1:0] dummy_q,   dummy_d;
    logic [REG_SIZE-1:0] wrap_lo_q, wrap_lo_d;
    logic [REG_SIZE-1:0] wrap_hi_q, wrap_hi_d;
    logic [REG_SIZE-1:0] shadow_q,  shadow_d;
    logic [REG_SIZE-1:0] scratch_q, scratch_d;
    logic                cfg_update_q, cfg_update_d;
    logic [REG_SIZE-1:0] w_status;
    logic                w_locked;
    logic                w_status_clr;

    assign w_locked     = ctrl_q[LOCK_BIT];
    assign w_status_clr = rd_req && (rd_addr == A_STATUS);

    // Write decode: lock blocks addresses 0..3 entirely, SCRATCH always writes
    always_comb begin
        ctrl_d       = ctrl_q;
        dummy_d      = dummy_q;
        wrap_lo_d    = wrap_lo_q;
        wrap_hi_d    = wrap_hi_q;
        shadow_d     = shadow_q;
        scratch_d    = scratch_q;
        cfg_update_d = 1'b0;
        if (wr_data_valid) begin
            if (wr_addr == A_SCRATCH) begin
                scratch_d = wr_data;
            end else if (!w_locked) begin
                if (wr_addr == A_CTRL) begin
                    ctrl_d           = wr_data;
                    ctrl_d[LOCK_BIT] = wr_data[LOCK_BIT] | ctrl_q[LOCK_BIT];
                    cfg_update_d     = 1'b1;
                end else if (wr_addr == A_DUMMY) begin
                    if (wr_data != '0) begin
                        dummy_d      = wr_data;
                        cfg_update_d = 1'b1;
                    end
                end else if (wr_addr == A_WRAP_LO) begin
                    shadow_d = wr_data;
                end else if (wr_addr == A_WRAP_HI) begin
                    wrap_hi_d    = wr_data;
                    wrap_lo_d    = shadow_q;
                    cfg_update_d = 1'b1;
                end
            end
        end
    end

    // Register state and config-update pulse
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q       <= REG_SIZE'(CTRL_RST);
            dummy_q      <= REG_SIZE'(DUMMY_RST);
            wrap_lo_q    <= REG_SIZE'(WRAP_RST);
            wrap_hi_q    <= REG_SIZE'(WRAP_RST);
            shadow_q     <= REG_SIZE'(WRAP_RST);
            scratch_q    <= REG_SIZE'(SCRATCH_RST);
            cfg_update_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            dummy_q      <= dummy_d;
            wrap_lo_q    <= wrap_lo_d;
            wrap_hi_q    <= wrap_hi_d;
            shadow_q     <= shadow_d;
            scratch_q    <= scratch_d;
            cfg_update_q <= cfg_update_d;
        end
    end

    spi_slave_status_reg #(
        .WIDTH   (REG_SIZE),
        .RST_VAL (REG_SIZE'(STATUS_RST))
    ) u_status (
        .clk_i  (sclk),
        .rst_ni (rstn),
        .set_i  (status_set),
        .clr_i  (w_status_clr),
        .q_o    (w_status)
    );

    // Combinational read mux; WRAP_LO returns the active byte, not the shadow
    always_comb begin
        rd_data = '0;
        if (rd_addr == A_CTRL) begin
            rd_data = ctrl_q;
        end else if (rd_addr == A_DUMMY) begin
            rd_data = dummy_q;
        end else if (rd_addr == A_WRAP_LO) begin
            rd_data = wrap_lo_q;
        end else if (rd_addr == A_WRAP_HI) begin
            rd_data = wrap_hi_q;
        end else if (rd_addr == A_STATUS) begin
            rd_data = w_status;
        end else if (rd_addr == A_SCRATCH) begin
            rd_data = scratch_q;
        end
    end

    assign dummy_cycles = dummy_q[7:0];
    assign en_qpi       = ctrl_q[CTRL_QPI_BIT];
    assign locked       = w_locked;
    assign wrap_length  = {wrap_hi_q, wrap_lo_q} + WRAP_W'(1);
    assign cfg_update   = cfg_update_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_regfile
// Description : Directed self-checking bench for spi_slave_regfile with
//               default parameters (8-bit registers, 8 address slots).
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_spi_slave_regfile;

    logic        sclk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  wr_addr = '0;
    logic        wr_data_valid = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_data;
    logic [7:0]  status_set = '0;
    logic [7:0]  dummy_cycles;
    logic        en_qpi;
    logic [15:0] wrap_length;
    logic        locked;
    logic        cfg_update;

    int total = 0;
    int bad   = 0;

    always #5 sclk = ~sclk;

    spi_slave_regfile dut (
        .sclk          (sclk),
        .rstn          (rstn),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_data_valid (wr_data_valid),
        .rd_addr       (rd_addr),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .status_set    (status_set),
        .dummy_cycles  (dummy_cycles),
        .en_qpi        (en_qpi),
        .wrap_length   (wrap_length),
        .locked        (locked),
        .cfg_update    (cfg_update)
    );

    // One write cycle; returns on the falling edge after the capturing edge
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge sclk);
        wr_addr       = a;
        wr_data       = d;
        wr_data_valid = 1'b1;
        @(negedge sclk);
        wr_data_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            total++;
            if (rd_data !== exp_rd[i]) begin
                bad++;
                $display("FAIL reset_rd addr=%0d got=%h exp=%h", i, rd_data, exp_rd[i]);
            end
        end
        total++;
        if (wrap_length !== 16'h0001 || cfg_update !== 1'b0 || dummy_cycles !== 8'd32 ||
            en_qpi !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got wl=%h cu=%b dc=%0d qpi=%b lk=%b exp wl=0001 cu=0 dc=32 qpi=0 lk=0",
                     wrap_length, cfg_update, dummy_cycles, en_qpi, locked);
        end
    endtask

    task automatic test_wrap;
        wr(3'd2, 8'hFF);
        rd_addr = 3'd2;
        #1;
        total++;
        if (wrap_length !== 16'h0001 || rd_data !== 8'h00 || cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL wrap_lo_shadow got wl=%h rd=%h cu=%b exp wl=0001 rd=00 cu=0",
                     wrap_length, rd_data, cfg_update);
        end
        wr(3'd3, 8'h00);
        total++;
        if (wrap_length !== 16'h0100 || cfg_update !== 1'b1) begin
            bad++;
            $display("FAIL wrap_commit got wl=%h cu=%b exp wl=0100 cu=1", wrap_length, cfg_update);
        end
        @(negedge sclk);
        total++;
        if (cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pulse_width got cu=%b exp cu=0", cfg_update);
        end
        wr(3'd2, 8'hFF);
        wr(3'd3, 8'hFF);
        total++;
        if (wrap_length !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_overflow got wl=%h exp wl=0000", wrap_length);
        end
    endtask

    task automatic test_dummy;
        wr(3'd1, 8'h00);
        rd_addr = 3'd1;
        #1;
        total++;
        if (rd_data !== 8'h20 || dummy_cycles !== 8'd32 || cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL dummy_zero got rd=%h dc=%0d cu=%b exp rd=20 dc=32 cu=0",
                     rd_data, dummy_cycles, cfg_update);
        end
        wr(3'd1, 8'h08);
        total++;
        if (dummy_cycles !== 8'd8 || cfg_update !== 1'b1) begin
            bad++;
            $display("FAIL dummy_write got dc=%0d cu=%b exp dc=8 cu=1", dummy_cycles, cfg_update);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge sclk);
        wr_data_valid = 1'b1;
        wr_addr       = 3'd0;
        wr_data       = 8'h01;
        @(negedge sclk);
        total++;
        if (cfg_update !== 1'b1 || en_qpi !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got cu=%b qpi=%b exp cu=1 qpi=1", cfg_update, en_qpi);
        end
        wr_addr = 3'd1;
        wr_data = 8'h09;
        @(negedge sclk);
        wr_data_valid = 1'b0;
        total++;
        if (cfg_update !== 1'b1 || dummy_cycles !== 8'd9) begin
            bad++;
            $display("FAIL b2b_second got cu=%b dc=%0d exp cu=1 dc=9", cfg_update, dummy_cycles);
        end
        wr(3'd5, 8'h3C);
        total++;
        if (cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL scratch_no_pulse got cu=%b exp cu=0", cfg_update);
        end
    endtask

    task automatic test_lock;
        logic [7:0] wl_before;
        wr(3'd0, 8'h81);
        total++;
        if (en_qpi !== 1'b1 || locked !== 1'b1 || cfg_update !== 1'b1) begin
            bad++;
            $display("FAIL lock_set got qpi=%b lk=%b cu=%b exp qpi=1 lk=1 cu=1", en_qpi, locked, cfg_update);
        end
        wl_before = 8'h00;
        wr(3'd0, 8'h00);
        total++;
        if (en_qpi !== 1'b1 || locked !== 1'b1 || cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL lock_ctrl got qpi=%b lk=%b cu=%b exp qpi=1 lk=1 cu=0", en_qpi, locked, cfg_update);
        end
        wr(3'd1, 8'h10);
        total++;
        if (dummy_cycles !== 8'd9 || cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL lock_dummy got dc=%0d cu=%b exp dc=9 cu=0", dummy_cycles, cfg_update);
        end
        wr(3'd2, 8'h22);
        wr(3'd3, 8'h05);
        rd_addr = 3'd3;
        #1;
        total++;
        if (wrap_length !== {wl_before, wl_before} || rd_data !== 8'hFF || cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL lock_wrap got wl=%h rd=%h cu=%b exp wl=0000 rd=ff cu=0",
                     wrap_length, rd_data, cfg_update);
        end
        wr(3'd5, 8'hA5);
        rd_addr = 3'd5;
        #1;
        total++;
        if (rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL lock_scratch got=%h exp=a5", rd_data);
        end
        @(negedge sclk);
        rstn = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || en_qpi !== 1'b0) begin
            bad++;
            $display("FAIL lock_reset got lk=%b qpi=%b exp lk=0 qpi=0", locked, en_qpi);
        end
        @(negedge sclk);
        rstn = 1'b1;
    endtask

    task automatic test_status;
        @(negedge sclk);
        status_set = 8'h03;
        @(negedge sclk);
        status_set = 8'h00;
        rd_addr    = 3'd4;
        @(negedge sclk);
        total++;
        if (rd_data !== 8'h03) begin
            bad++;
            $display("FAIL status_sticky got=%h exp=03", rd_data);
        end
        status_set = 8'h04;
        rd_req     = 1'b1;
        #1;
        total++;
        if (rd_data !== 8'h03) begin
            bad++;
            $display("FAIL status_read got=%h exp=03", rd_data);
        end
        @(negedge sclk);
        status_set = 8'h00;
        rd_req     = 1'b0;
        #1;
        total++;
        if (rd_data !== 8'h04) begin
            bad++;
            $display("FAIL status_set_wins got=%h exp=04", rd_data);
        end
    endtask

    task automatic test_async_reset;
        wr(3'd0, 8'h01);
        wr(3'd2, 8'h77);
        @(posedge sclk);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (en_qpi !== 1'b0 || wrap_length !== 16'h0001 || dummy_cycles !== 8'd32) begin
            bad++;
            $display("FAIL async_reset got qpi=%b wl=%h dc=%0d exp qpi=0 wl=0001 dc=32",
                     en_qpi, wrap_length, dummy_cycles);
        end
        @(negedge sclk);
        rstn = 1'b1;
        wr(3'd3, 8'h01);
        rd_addr = 3'd2;
        #1;
        total++;
        if (wrap_length !== 16'h0101 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL shadow_cleared got wl=%h lo=%h exp wl=0101 lo=00", wrap_length, rd_data);
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge sclk);
        rstn = 1'b1;
        test_reset();
        test_wrap();
        test_dummy();
        test_back_to_back();
        test_lock();
        test_status();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
Parametrised successor to the SPI slave configuration registers. It sits in the sclk domain between the SPI command decoder and the datapath. It provides a generic-width register file with these additions over the previous block:
- a lock bit
- atomic two-step commit of the wrap length
- a sticky clear-on-read status register
- a scratch register
- a one-cycle config-update pulse for the downstream controller.

Parameters:
REG_SIZE, 8, width of each register and of wr_data/rd_data (min 8).
NUM_REGS, 8, number of address slots (min 6); ADDR_W = $clog2(NUM_REGS) is a localparam.
DUMMY_RST, 32, reset value of DUMMY register (must fit in 8 bits).
WRAP_W = 2*REG_SIZE is a localparam, the width of wrap_length.

Ports:
sclk  in  1  SPI clock; all state on rising edge
rstn  in  1  asynchronous active-low reset
wr_data  in  REG_SIZE  write data
wr_addr  in  ADDR_W  write address
wr_data_valid  in  1  write strobe, one write per asserted cycle
rd_addr  in  ADDR_W  read address
rd_req  in  1  read strobe; qualifies clear-on-read side effects only
rd_data  out  REG_SIZE  combinational read data for rd_addr
status_set  in  REG_SIZE  per-bit hardware set of STATUS
dummy_cycles  out  8  DUMMY[7:0]
en_qpi  out  1  CTRL[0]
wrap_length  out  WRAP_W  {WRAP_HI,WRAP_LO} active value + 1, modulo 2^WRAP_W
locked  out  1  CTRL[REG_SIZE-1]
cfg_update  out  1  registered one-cycle pulse after an accepted config write

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low. Ports are sclk and rstn.

Reset state:
- CTRL=0, DUMMY=DUMMY_RST, WRAP_LO/HI active=0, wrap shadow=0, STATUS=0, SCRATCH=0, cfg_update=0.
- Resulting outputs: en_qpi=0, locked=0, dummy_cycles=DUMMY_RST, wrap_length=1.
- Reset mid-sequence (shadow written, HI not yet written) discards the shadow.

Register map:
- 0 CTRL:
  - bit0 en_qpi.
  - bit REG_SIZE-1 lock: set-only, cleared only by rstn. A write with lock=1 sets it and also applies bit0 in the same write.
  - Other bits store and read back.
- 1 DUMMY: plain RW. A write of 0 is ignored: the register keeps its value and no cfg_update is generated.
- 2 WRAP_LO: a write goes to the shadow only. Reads return the active low byte, not the shadow.
- 3 WRAP_HI: a write commits {wr_data, shadow} to the active pair in one cycle, so wrap_length changes atomically. Writing HI without a prior LO write commits the current shadow value.
- 4 STATUS: read-only, sticky.
  - Each cycle: STATUS <= (STATUS & ~clr) | status_set.
  - clr = all-ones when rd_req && rd_addr==4, else 0.
  - Set wins over clear in the same cycle. Writes are ignored.
- 5 SCRATCH: plain RW, unaffected by lock.
- 6..2^ADDR_W-1: read 0, writes ignored.

Lock:
- While locked=1, writes to addresses 0..3 are ignored entirely: no shadow update, no commit, no cfg_update.
- Writes to SCRATCH still work. STATUS behaviour is unchanged.

Latency:
- A register write is visible on rd_data and on the decoded outputs in the cycle after wr_data_valid.
- cfg_update is high in that same cycle, for exactly one cycle, after an accepted write to CTRL, to DUMMY (non-zero), or to WRAP_HI.
- WRAP_LO writes and SCRATCH writes do not pulse cfg_update.
- Back-to-back accepted writes give back-to-back pulses.

Arithmetic and read path:
- wrap_length is WRAP_W-bit unsigned. Active 0xFFFF (REG_SIZE=8) yields 0.
- rd_data is purely combinational. There are no side effects without rd_req.

Decomposition:
- Package spi_slave_regfile_pkg holds:
  - address constants ADDR_CTRL..ADDR_SCRATCH
  - the CTRL_QPI_BIT index; the lock bit is derived from REG_SIZE
  - default reset values.
- One sub-module: spi_slave_status_reg, the parametrised sticky set/clear-on-read register, instantiated for STATUS.

Test Plan:
1. Reset, then read all addresses -> CTRL=0x00, DUMMY=0x20, WRAP=0/0, STATUS=0, SCRATCH=0, addr 6/7 read 0; wrap_length=1, cfg_update=0.
2. Write LO=0xFF, check wrap_length still 1 and addr 2 reads 0x00; write HI=0x00 -> wrap_length=0x0100 next cycle, cfg_update pulses once; then LO=0xFF, HI=0xFF -> wrap_length=0x0000.
3. Write DUMMY=0x00 -> DUMMY stays 0x20, no cfg_update; write DUMMY=0x08 -> dummy_cycles=8, one cfg_update pulse.
4. Write CTRL=0x81 -> en_qpi=1, locked=1; then CTRL=0x00, DUMMY=0x10, HI=0x05 -> all ignored, no pulses; SCRATCH=0xA5 reads back 0xA5; rstn low -> locked=0, en_qpi=0.
5. status_set=0x03 for one cycle -> STATUS=0x03 held; rd_req with rd_addr=4 alongside status_set=0x04 -> rd_data=0x03 that cycle, STATUS=0x04 next.
6. Assert rstn mid-cycle asynchronously after an LO write -> outputs reset immediately; a later HI=0x01 write commits 0x0100 (shadow cleared).
